// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the two-input arbitrating output register.
// Optional per-input transfer counters are enabled with ARB_MUX_CNT_EN.
package arb_mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter; the last pointer moves only on an accepted grant.
// Reset leaves last=1 so requester 0 wins the first tie.
module rr_arb_2
    import arb_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (adv)
            last <= gnt[1];
    end

endmodule

// File: rtl/arb_mux_2x1.sv
// Two-requester round-robin mux feeding a one-entry valid/ready output register.
// Define ARB_MUX_CNT_EN to add saturating per-input transfer counters cnt0/cnt1.
module arb_mux_2x1
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic             vld0,
    input  logic             vld1,
    output logic             rdy0,
    output logic             rdy1,
    output logic [WIDTH-1:0] dout,
    output logic             vout,
    input  logic             rdy_in,
    output logic             s
`ifdef ARB_MUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] gnt;
    logic       open;
    logic       take;

    // Reset masks the readies so nothing is accepted in a reset cycle.
    assign open = (state == EMPTY) || rdy_in;
    assign rdy0 = !rst && open && gnt[0];
    assign rdy1 = !rst && open && gnt[1];
    assign take = rdy0 || rdy1;
    assign vout = (state == FULL);

    rr_arb_2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({vld1, vld0}),
        .adv (take),
        .gnt (gnt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (take) state_nxt = FULL;
            FULL: begin
                if (take)
                    state_nxt = FULL;
                else if (rdy_in)
                    state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            s    <= 1'b0;
        end else if (take) begin
            dout <= rdy1 ? din1 : din0;
            s    <= rdy1;
        end
    end

`ifdef ARB_MUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (rdy0 && cnt0 != CNT_MAX)
                cnt0 <= cnt0 + 1'b1;
            if (rdy1 && cnt1 != CNT_MAX)
                cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_2x1.sv
// Directed and random stimulus for arb_mux_2x1 checked against a transaction-level model.
// Counter checks are included when ARB_MUX_CNT_EN is defined.
module tb_arb_mux_2x1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = '0;
    logic [7:0] din1 = '0;
    logic       vld0 = 1'b0;
    logic       vld1 = 1'b0;
    logic       rdy0;
    logic       rdy1;
    logic [7:0] dout;
    logic       vout;
    logic       rdy_in = 1'b1;
    logic       s;
`ifdef ARB_MUX_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    arb_mux_2x1 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .din0   (din0),
        .din1   (din1),
        .vld0   (vld0),
        .vld1   (vld1),
        .rdy0   (rdy0),
        .rdy1   (rdy1),
        .dout   (dout),
        .vout   (vout),
        .rdy_in (rdy_in),
        .s      (s)
`ifdef ARB_MUX_CNT_EN
        ,
        .cnt0   (cnt0),
        .cnt1   (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    bit run  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a queue holds what sits in the output slot.
    typedef struct {
        int         idx;
        logic [7:0] data;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_dout = '0;
    int         m_s    = 0;
    int         m_last = 1;
    int         m_cnt[2] = '{0, 0};

    function automatic int pick(input logic a, input logic b, input int lastw);
        if (a && b) return (lastw == 0) ? 1 : 0;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    initial forever begin
        int  w;
        bit  op;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_dout = '0;
            m_s    = 0;
            m_last = 1;
            m_cnt  = '{0, 0};
        end else begin
            op = (mq.size() == 0) || rdy_in;
            w  = pick(vld0, vld1, m_last);
            if (mq.size() != 0 && rdy_in)
                void'(mq.pop_front());
            if (op && w >= 0) begin
                ent_t e;
                e.idx  = w;
                e.data = (w == 1) ? din1 : din0;
                mq.push_back(e);
                m_dout = e.data;
                m_s    = w;
                m_last = w;
                if (m_cnt[w] != 65535) m_cnt[w]++;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            int w;
            bit op;
            op = !rst && ((mq.size() == 0) || rdy_in);
            w  = pick(vld0, vld1, m_last);
            chk("rdy0", 32'(rdy0), 32'(op && w == 0));
            chk("rdy1", 32'(rdy1), 32'(op && w == 1));
            chk("vout", 32'(vout), 32'(mq.size() == 1));
            chk("dout", 32'(dout), 32'(m_dout));
            chk("s", 32'(s), 32'(m_s));
`ifdef ARB_MUX_CNT_EN
            chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
            chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        run = 1'b1;
        chk("rst_vout", 32'(vout), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        vld0 = 1'b1;
        din0 = 8'hA5;
        #1;
        chk("rst_rdy0", 32'(rdy0), 32'd0);

        // single requester
        rst = 1'b0;
        #1;
        chk("single_rdy0", 32'(rdy0), 32'd1);
        chk("single_rdy1", 32'(rdy1), 32'd0);
        tick();
        vld0 = 1'b0;
        chk("single_vout", 32'(vout), 32'd1);
        chk("single_dout", 32'(dout), 32'hA5);
        chk("single_s", 32'(s), 32'd0);
        chk("single_rdy1b", 32'(rdy1), 32'd0);

        // drain
        tick();
        chk("drain_vout", 32'(vout), 32'd0);
        chk("drain_dout", 32'(dout), 32'hA5);

        // tie after reset
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        vld0 = 1'b1;
        vld1 = 1'b1;
        din0 = 8'h11;
        din1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_dout", 32'(dout), (i % 2 == 0) ? 32'h11 : 32'h22);
            chk("tie_s", 32'(s), 32'(i % 2));
        end

        // backpressure
        vld1 = 1'b0;
        din0 = 8'h33;
        tick();
        chk("bp_load", 32'(dout), 32'h33);
        vld0   = 1'b0;
        vld1   = 1'b1;
        din1   = 8'h44;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy0", 32'(rdy0), 32'd0);
            chk("bp_rdy1", 32'(rdy1), 32'd0);
            tick();
            chk("bp_dout", 32'(dout), 32'h33);
            chk("bp_vout", 32'(vout), 32'd1);
        end
        rdy_in = 1'b1;
        #1;
        chk("bp_rel_rdy1", 32'(rdy1), 32'd1);
        tick();
        vld1 = 1'b0;
        chk("bp_rel_dout", 32'(dout), 32'h44);
        chk("bp_rel_s", 32'(s), 32'd1);
        tick();

        // reset mid-operation
        vld1 = 1'b1;
        din1 = 8'h55;
        tick();
        chk("mid_full", 32'(dout), 32'h55);
        rst = 1'b1;
        tick();
        chk("mid_vout", 32'(vout), 32'd0);
        chk("mid_dout", 32'(dout), 32'd0);
        rst  = 1'b0;
        vld0 = 1'b1;
        din0 = 8'h66;
        din1 = 8'h77;
        tick();
        chk("mid_tie", 32'(dout), 32'h66);
        chk("mid_tie_s", 32'(s), 32'd0);

        // deasserted valid with changing data
        vld0 = 1'b0;
        vld1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din0 = 8'(i + 8'hC0);
            din1 = 8'(i + 8'hD0);
            tick();
        end
        chk("idle_vout", 32'(vout), 32'd0);
        chk("idle_dout", 32'(dout), 32'h66);

        // random traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            vld0   = 1'($urandom_range(0, 1));
            vld1   = 1'($urandom_range(0, 1));
            din0   = 8'($urandom);
            din1   = 8'($urandom);
            rdy_in = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst    = 1'b0;
        vld0   = 1'b0;
        vld1   = 1'b0;
        rdy_in = 1'b1;
        tick();

`ifdef ARB_MUX_CNT_EN
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        vld1 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vld1 = 1'b0;
        tick();
        chk("cnt1_5", 32'(cnt1), 32'd5);
        chk("cnt0_0", 32'(cnt0), 32'd0);
        vld1 = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        vld1 = 1'b0;
        tick();
        chk("cnt1_sat", 32'(cnt1), 32'hFFFF);
`endif

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
